// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous VRAM between display fetch and CPU.
// Video has priority; a wait counter bounds CPU latency.
module vram_arbiter #(
  parameter int AW           = 11,
  parameter int DW           = 8,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  output logic          vid_overrun,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_ready,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int WW = (CPU_MAX_WAIT < 1) ? 1
                    : $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {
    TAG_IDLE,
    TAG_VID,
    TAG_CRD,
    TAG_CWR
  } tag_t;

  logic          vid_pend;
  logic [AW-1:0] vid_pa;
  logic          cpu_pend;
  logic          cpu_pwe;
  logic [AW-1:0] cpu_pa;
  logic [DW-1:0] cpu_pwd;
  logic [WW-1:0] cpu_wait;
  tag_t          s1;
  tag_t          s2;

  logic gnt_cpu;
  logic gnt_vid;
  logic starve;
  logic cpu_busy;
  logic cpu_take;
  tag_t tag_nxt;

  // grant decision from registered pend flags only
  always_comb begin
    starve   = 1'b0;
    gnt_cpu  = 1'b0;
    gnt_vid  = 1'b0;
    cpu_busy = 1'b0;
    cpu_take = 1'b0;
    tag_nxt  = TAG_IDLE;
    starve   = cpu_wait >= WMAX;
    gnt_cpu  = cpu_pend && (!vid_pend || starve);
    gnt_vid  = vid_pend && !gnt_cpu;
    cpu_busy = cpu_pend
             || s1 == TAG_CRD || s1 == TAG_CWR
             || s2 == TAG_CRD || s2 == TAG_CWR;
    cpu_take = cpu_req && !cpu_busy && !cpu_ack;
    unique case (1'b1)
      gnt_cpu: tag_nxt = cpu_pwe ? TAG_CWR : TAG_CRD;
      gnt_vid: tag_nxt = TAG_VID;
      default: tag_nxt = TAG_IDLE;
    endcase
  end

  assign cpu_ready = ~cpu_busy;

  // request capture, overrun detection and starvation count
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      vid_pend    <= 1'b0;
      vid_pa      <= '0;
      vid_overrun <= 1'b0;
      cpu_pend    <= 1'b0;
      cpu_pwe     <= 1'b0;
      cpu_pa      <= '0;
      cpu_pwd     <= '0;
      cpu_wait    <= '0;
    end else begin
      if (vid_req) begin
        vid_pend <= 1'b1;
        vid_pa   <= vid_addr;
        if (vid_pend && !gnt_vid)
          vid_overrun <= 1'b1;
      end else if (gnt_vid) begin
        vid_pend <= 1'b0;
      end
      if (cpu_take) begin
        cpu_pend <= 1'b1;
        cpu_pwe  <= cpu_we;
        cpu_pa   <= cpu_addr;
        cpu_pwd  <= cpu_wdata;
      end else if (gnt_cpu) begin
        cpu_pend <= 1'b0;
      end
      if (gnt_cpu)
        cpu_wait <= '0;
      else if (cpu_pend && gnt_vid && cpu_wait != WMAX)
        cpu_wait <= cpu_wait + 1'b1;
    end
  end

  // RAM port registers and tag pipeline
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      s1        <= TAG_IDLE;
      s2        <= TAG_IDLE;
    end else begin
      ram_we <= gnt_cpu & cpu_pwe;
      if (gnt_cpu) begin
        ram_addr  <= cpu_pa;
        ram_wdata <= cpu_pwd;
      end else if (gnt_vid) begin
        ram_addr <= vid_pa;
      end
      s1 <= tag_nxt;
      s2 <= s1;
    end
  end

  // completion: route returned data by stage-2 tag
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      vid_data  <= '0;
      vid_valid <= 1'b0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      vid_valid <= s2 == TAG_VID;
      cpu_ack   <= s2 == TAG_CRD || s2 == TAG_CWR;
      if (s2 == TAG_VID)
        vid_data <= ram_rdata;
      if (s2 == TAG_CRD)
        cpu_rdata <= ram_rdata;
    end
  end

endmodule
